// File: rtl/dat_fifo.sv
// First-word-fall-through word buffer shared by both SD data directions.
// Optional `DAT_FIFO_LEVEL_EN adds the level/half occupancy outputs.
module dat_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sd_clock,
  input  logic                  reset,
  input  logic                  writeread,
  input  logic                  flush,
  input  logic                  host_push,
  input  logic [WIDTH-1:0]      host_data_in,
  input  logic                  host_pop,
  output logic [WIDTH-1:0]      host_data_out,
  input  logic                  read_enable,
  output logic [WIDTH-1:0]      dataFROMFIFO,
  input  logic                  write_enable,
  input  logic [WIDTH-1:0]      dataToFIFO,
  output logic                  status,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
`ifdef DAT_FIFO_LEVEL_EN
  output logic [DEPTH_LOG2:0]   level,
  output logic                  half,
`endif
  output logic                  underflow
);

  localparam int ENTRIES = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] FULL_XOR = (DEPTH_LOG2+1)'(ENTRIES);

  logic [WIDTH-1:0]    mem [ENTRIES];
  logic [DEPTH_LOG2:0] wptr;
  logic [DEPTH_LOG2:0] rptr;
  logic                writeread_p1;

  logic             clr;
  logic             push;
  logic             pop;
  logic             do_push;
  logic             do_pop;
  logic             ovf_evt;
  logic             unf_evt;
  logic [WIDTH-1:0] push_data;

  // A direction change behaves like a flush and swallows that cycle's strobes.
  assign clr       = flush | (writeread != writeread_p1);
  assign push      = writeread ? host_push : write_enable;
  assign pop       = writeread ? read_enable : host_pop;
  assign push_data = writeread ? host_data_in : dataToFIFO;

  assign empty = (wptr == rptr);
  assign full  = ((wptr ^ rptr) == FULL_XOR);

  assign do_pop  = ~clr & pop & ~empty;
  assign do_push = ~clr & push & (~full | pop);
  assign ovf_evt = ~clr & push & full & ~pop;
  assign unf_evt = ~clr & pop & empty;

  assign status        = writeread ? ~empty : ~full;
  assign host_data_out = mem[rptr[DEPTH_LOG2-1:0]];
  assign dataFROMFIFO  = mem[rptr[DEPTH_LOG2-1:0]];

`ifdef DAT_FIFO_LEVEL_EN
  localparam logic [DEPTH_LOG2:0] HALF_LVL = (DEPTH_LOG2+1)'(ENTRIES / 2);
  assign level = wptr - rptr;
  assign half  = (level >= HALF_LVL);
`endif

  // Control state: pointers, sticky flags and the direction history.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      writeread_p1 <= 1'b0;
    end else begin
      writeread_p1 <= writeread;
      if (clr) begin
        wptr      <= '0;
        rptr      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (do_push) wptr <= wptr + PTR_ONE;
        if (do_pop)  rptr <= rptr + PTR_ONE;
        if (ovf_evt) overflow  <= 1'b1;
        if (unf_evt) underflow <= 1'b1;
      end
    end
  end

  // Storage array: data only, never reset.
  always_ff @(posedge sd_clock) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_dat_fifo.sv
// Self-checking bench for dat_fifo against a queue-based reference model.
module tb_dat_fifo;
  localparam int W = 32;
  localparam int DL = 4;
  localparam int DEPTH = 16;

  logic sd_clock = 1'b0;
  logic reset = 1'b1;
  logic writeread = 1'b0;
  logic flush = 1'b0;
  logic host_push = 1'b0;
  logic host_pop = 1'b0;
  logic read_enable = 1'b0;
  logic write_enable = 1'b0;
  logic [W-1:0] host_data_in = '0;
  logic [W-1:0] dataToFIFO = '0;
  logic [W-1:0] host_data_out;
  logic [W-1:0] dataFROMFIFO;
  logic status, full, empty, overflow, underflow;
`ifdef DAT_FIFO_LEVEL_EN
  logic [DL:0] level;
  logic half;
`endif

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_wrq = 0;

  dat_fifo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .sd_clock(sd_clock), .reset(reset), .writeread(writeread), .flush(flush),
    .host_push(host_push), .host_data_in(host_data_in), .host_pop(host_pop),
    .host_data_out(host_data_out), .read_enable(read_enable),
    .dataFROMFIFO(dataFROMFIFO), .write_enable(write_enable),
    .dataToFIFO(dataToFIFO), .status(status), .full(full), .empty(empty),
    .overflow(overflow),
`ifdef DAT_FIFO_LEVEL_EN
    .level(level), .half(half),
`endif
    .underflow(underflow)
  );

  always #5 sd_clock = ~sd_clock;

  function automatic bit exp_status();
    return writeread ? (mq.size() != 0) : (mq.size() != DEPTH);
  endfunction

  // One clock: apply the FIFO rules to the queue, sample 1 time unit later, drop strobes.
  task automatic tick();
    bit push, pop;
    @(posedge sd_clock);
    if (writeread !== m_wrq || flush) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      push = writeread ? host_push : write_enable;
      pop  = writeread ? read_enable : host_pop;
      if (pop && mq.size() == 0) begin m_unf = 1; pop = 0; end
      if (push && mq.size() == DEPTH && !pop) begin m_ovf = 1; push = 0; end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(writeread ? host_data_in : dataToFIFO);
    end
    m_wrq = writeread;
    #1;
    host_push = 0; host_pop = 0; read_enable = 0; write_enable = 0; flush = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (status !== 1'b1) begin failures++; $display("FAIL reset_status: got %b want 1", status); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_flags: got %b%b want 00", overflow, underflow); end
`ifdef DAT_FIFO_LEVEL_EN
    checks++; if (level !== '0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
`endif
    @(negedge sd_clock); reset = 0;
    @(posedge sd_clock); #1;
  endtask

  task automatic test_tx_fill_drain();
    writeread = 1; tick();
    for (int i = 1; i <= DEPTH; i++) begin
      host_push = 1; host_data_in = i; tick();
      checks++; if (empty !== 1'b0) begin failures++; $display("FAIL tx_fill_empty[%0d]: got %b want 0", i, empty); end
    end
    checks++; if (full !== 1'b1 || status !== 1'b1) begin failures++; $display("FAIL tx_full_status: got full=%b status=%b want 1 1", full, status); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (dataFROMFIFO !== W'(i)) begin failures++; $display("FAIL tx_drain_data[%0d]: got %h want %h", i, dataFROMFIFO, W'(i)); end
      read_enable = 1; tick();
    end
    checks++; if (empty !== 1'b1 || status !== 1'b0) begin failures++; $display("FAIL tx_drain_end: got empty=%b status=%b want 1 0", empty, status); end
  endtask

  task automatic test_rx_status();
    logic [W-1:0] words[DEPTH];
    writeread = 0; tick();
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = $urandom; write_enable = 1; dataToFIFO = words[i]; tick();
    end
    checks++; if (status !== 1'b0 || full !== 1'b1) begin failures++; $display("FAIL rx_full_status: got status=%b full=%b want 0 1", status, full); end
    checks++; if (host_data_out !== words[0]) begin failures++; $display("FAIL rx_head: got %h want %h", host_data_out, words[0]); end
    host_pop = 1; tick();
    checks++; if (status !== 1'b1) begin failures++; $display("FAIL rx_status_after_pop: got %b want 1", status); end
    checks++; if (host_data_out !== words[1]) begin failures++; $display("FAIL rx_second_word: got %h want %h", host_data_out, words[1]); end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] head;
    writeread = 1; flush = 1; tick();
    for (int i = 0; i < DEPTH; i++) begin host_push = 1; host_data_in = $urandom; tick(); end
    host_push = 1; read_enable = 1; host_data_in = 32'hA5A5_0001; tick();
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL full_push_pop: got full=%b ovf=%b want 1 0", full, overflow); end
    checks++; if (dataFROMFIFO !== mq[0]) begin failures++; $display("FAIL full_push_pop_head: got %h want %h", dataFROMFIFO, mq[0]); end
    head = mq[0];
    host_push = 1; host_data_in = 32'hDEAD_BEEF; tick();
    checks++; if (overflow !== 1'b1 || full !== 1'b1) begin failures++; $display("FAIL overflow_set: got ovf=%b full=%b want 1 1", overflow, full); end
    checks++; if (dataFROMFIFO !== head) begin failures++; $display("FAIL overflow_head: got %h want %h", dataFROMFIFO, head); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (dataFROMFIFO !== mq[0]) begin failures++; $display("FAIL bnd_drain[%0d]: got %h want %h", i, dataFROMFIFO, mq[0]); end
      read_enable = 1; tick();
    end
    checks++; if (mq.size() == 0 && mq.size() == DEPTH) begin failures++; end
    checks--;
    read_enable = 1; tick();
    checks++; if (underflow !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL underflow_set: got unf=%b ovf=%b want 1 1", underflow, overflow); end
    flush = 1; tick();
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL flush_clear: got unf=%b ovf=%b empty=%b want 0 0 1", underflow, overflow, empty); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] nxt, exp_out;
    writeread = 1; flush = 1; tick();
    nxt = 32'h100; exp_out = 32'h100;
    for (int i = 0; i < 3; i++) begin host_push = 1; host_data_in = nxt; nxt++; tick(); end
    for (int i = 0; i < 40; i++) begin
      checks++; if (dataFROMFIFO !== exp_out) begin failures++; $display("FAIL wrap_data[%0d]: got %h want %h", i, dataFROMFIFO, exp_out); end
      host_push = 1; read_enable = 1; host_data_in = nxt; nxt++; exp_out++; tick();
    end
    checks++; if (mq.size() != 3 || empty !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL wrap_end: got empty=%b full=%b ovf=%b unf=%b want 0 0 0 0", empty, full, overflow, underflow); end
`ifdef DAT_FIFO_LEVEL_EN
    checks++; if (level !== 5'd3) begin failures++; $display("FAIL wrap_level: got %0d want 3", level); end
`endif
  endtask

  task automatic test_dir_switch();
    writeread = 1; flush = 1; tick();
    for (int i = 0; i < 5; i++) begin host_push = 1; host_data_in = $urandom; tick(); end
    writeread = 0; host_pop = 1; tick();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL dir_switch_empty: got %b want 1", empty); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL dir_switch_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_random();
    int pp;
    for (int i = 0; i < 400; i++) begin
      pp = ((i / 50) % 2 == 0) ? 75 : 30;
      if ($urandom_range(39) == 0) writeread = ~writeread;
      flush        = ($urandom_range(63) == 0);
      host_push    = ($urandom_range(99) < pp);
      write_enable = ($urandom_range(99) < pp);
      host_pop     = ($urandom_range(99) < 100 - pp);
      read_enable  = ($urandom_range(99) < 100 - pp);
      host_data_in = $urandom; dataToFIFO = $urandom;
      tick();
      checks++; if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin failures++; $display("FAIL rnd_flags[%0d]: got empty=%b full=%b want size=%0d", i, empty, full, mq.size()); end
      checks++; if (status !== exp_status()) begin failures++; $display("FAIL rnd_status[%0d]: got %b want %b", i, status, exp_status()); end
      checks++; if (overflow !== m_ovf || underflow !== m_unf) begin failures++; $display("FAIL rnd_sticky[%0d]: got %b%b want %b%b", i, overflow, underflow, m_ovf, m_unf); end
      if (mq.size() != 0) begin
        checks++; if (dataFROMFIFO !== mq[0] || host_data_out !== mq[0]) begin failures++; $display("FAIL rnd_data[%0d]: got %h/%h want %h", i, dataFROMFIFO, host_data_out, mq[0]); end
      end
`ifdef DAT_FIFO_LEVEL_EN
      checks++; if (level !== (DL+1)'(mq.size()) || half !== (mq.size() >= DEPTH/2)) begin failures++; $display("FAIL rnd_level[%0d]: got %0d/%b want %0d", i, level, half, mq.size()); end
`endif
    end
  endtask

  task automatic test_async_reset();
    writeread = 1; flush = 1; tick();
    for (int i = 0; i < 7; i++) begin host_push = 1; host_data_in = $urandom; tick(); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL pre_reset_empty: got %b want 0", empty); end
    #2 reset = 1;
    #1;
    mq.delete(); m_ovf = 0; m_unf = 0; m_wrq = 0;
    checks++; if (empty !== 1'b1 || full !== 1'b0 || status !== 1'b0) begin failures++; $display("FAIL async_reset: got empty=%b full=%b status=%b want 1 0 0", empty, full, status); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL async_reset_flags: got %b%b want 00", overflow, underflow); end
`ifdef DAT_FIFO_LEVEL_EN
    checks++; if (level !== '0 || half !== 1'b0) begin failures++; $display("FAIL async_reset_level: got %0d/%b want 0/0", level, half); end
`endif
    @(posedge sd_clock); #1 reset = 0;
    tick();
    host_push = 1; host_data_in = 32'h1234_5678; tick();
    checks++; if (dataFROMFIFO !== 32'h1234_5678 || empty !== 1'b0) begin failures++; $display("FAIL post_reset_push: got %h empty=%b want 12345678 0", dataFROMFIFO, empty); end
  endtask

  initial begin
    test_reset();
    test_tx_fill_drain();
    test_rx_status();
    test_boundaries();
    test_wrap();
    test_dir_switch();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dat_fifo.md
# dat_fifo

Word buffer between the host register interface and the `dat_phys` data-line stage of the SD host. It holds 32-bit data words for both transfer directions. On writes (host → card), the host pushes words and `dat_phys` pops them via `read_enable`/`dataFROMFIFO`/`status`. On reads (card → host), `dat_phys` pushes via `write_enable`/`dataToFIFO` and the host pops. Direction follows the same `writeread` signal that drives `dat_phys`.

## Interface
- `WIDTH`, 32, data word width.
- `DEPTH_LOG2`, 4, log2 of entry count (default 16 entries).
- `sd_clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `writeread`  in  1  1 = host→card (TX), 0 = card→host (RX).
- `flush`  in  1  synchronous clear of pointers and error flags.
- `host_push`  in  1  host writes `host_data_in` (honoured only when `writeread`=1).
- `host_data_in`  in  WIDTH  host write data.
- `host_pop`  in  1  host consumes head word (honoured only when `writeread`=0).
- `host_data_out`  out  WIDTH  head word, first-word-fall-through.
- `read_enable`  in  1  `dat_phys` consumes head word (honoured only when `writeread`=1).
- `dataFROMFIFO`  out  WIDTH  head word to `dat_phys`, FWFT.
- `write_enable`  in  1  `dat_phys` pushes `dataToFIFO` (honoured only when `writeread`=0).
- `dataToFIFO`  in  WIDTH  received word from `dat_phys`.
- `status`  out  1  TX: 1 when not empty (word ready to send). RX: 1 when not full (room to receive).
- `full`  out  1  count == 2^DEPTH_LOG2.
- `empty`  out  1  count == 0.
- `overflow`  out  1  sticky; set by a push while full with no concurrent pop.
- `underflow`  out  1  sticky; set by a pop while empty.

## Operation
- Storage: 2^DEPTH_LOG2 × WIDTH register array. Write pointer and read pointer are each DEPTH_LOG2+1 bits; the MSB disambiguates full from empty. Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Effective push = (`writeread` ? `host_push` : `write_enable`). Effective pop = (`writeread` ? `read_enable` : `host_pop`). Inactive-side strobes are ignored and do not set error flags.
- Push writes `mem[wptr[DEPTH_LOG2-1:0]]` and increments wptr. Pop increments rptr.
- `host_data_out` and `dataFROMFIFO` both show `mem[rptr]` combinationally. Their value is undefined-but-stable when empty.
- Push while full:
  - with a concurrent pop: both succeed, count unchanged.
  - without a concurrent pop: the write is dropped, pointers hold, `overflow` sets.
- Pop while empty: ignored and `underflow` sets. A concurrent push still succeeds.
- Direction change: `writeread` is registered each cycle. A cycle where `writeread` ≠ its registered value acts as an implicit flush. All strobes in that cycle are ignored.
- `flush` (or implicit flush) resets both pointers to 0 and clears `overflow` and `underflow`. Flush has priority over push and pop in the same cycle. Memory contents are not cleared.

## Timing
- Reset values:
  - `empty`=1, `full`=0, `status`=1 if `writeread`=0 else 0, `overflow`=0, `underflow`=0.
  - Pointers 0; registered `writeread`=0.
- `full`, `empty`, `status` are decoded from registered pointers and update the cycle after the causing edge.
- Push-to-visible latency: 1 cycle. A word pushed at edge N appears on the data outputs, and `empty` falls, after edge N.
- Pop latency: the next word is presented after the pop edge. There is no read-data pipeline.
- Reset mid-transfer: immediate return to the reset state. No partial word is retained.
- Back-to-back push or pop every cycle is supported indefinitely, including through pointer wrap.

## Configuration
- `DAT_FIFO_LEVEL_EN` defined:
  - adds output `level` [DEPTH_LOG2:0] = wptr − rptr, with reset value 0;
  - adds output `half`, 1 when `level` ≥ 2^(DEPTH_LOG2−1).
  - Both are registered-pointer decodes with the same 1-cycle latency as `full`.
- Not defined: neither port exists, and the count subtractor is not synthesised.

## Test plan
- TX fill/drain: `writeread`=1; push 0x1..0x10 on 16 consecutive cycles → `full`=1, `status`=1. Then `read_enable` for 16 cycles → `dataFROMFIFO` reads 0x1..0x10 in order, then `empty`=1, `status`=0.
- RX status: `writeread`=0; 16 `write_enable` pushes → `status`=0. One `host_pop` → `status`=1 one cycle later, and `host_data_out` = second word.
- Boundaries:
  - at full, simultaneous push and pop → count stays 16, `overflow`=0;
  - a 17th push alone → `overflow`=1, data unchanged;
  - pop when empty → `underflow`=1;
  - `flush` → both flags clear and `empty`=1.
- Wrap: 40 interleaved push/pop with occupancy 3 using an incrementing pattern → output sequence matches exactly across pointer wrap.
- Direction switch: 5 words in TX, toggle `writeread` to 0 with `host_pop` asserted → `empty`=1 next cycle, pop ignored, `underflow`=0.
- Async reset mid-fill: assert `reset` between edges with 7 words stored → outputs return to reset values immediately; `level`=0 when `DAT_FIFO_LEVEL_EN` is defined.
